// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and widths for the PLL reset supervisor.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 100000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HB_TIMEOUT    = 64;
    localparam int DEF_CNT_W         = 20;
    localparam int RETRY_W           = 8;

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by async reset.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on the free-running reference clock.
// Define PLL_HEARTBEAT_EN to also treat a stalled pll_hb toggle in RUN as a lock loss.
//
// state  | meaning
// RST    | PLL reset held for RST_CYCLES
// WAIT   | PLL released, up to LOCK_TIMEOUT cycles allowed for lock
// STABLE | lock seen, must hold continuously for STABLE_CYCLES
// RUN    | fabric reset released, supervising lock (and heartbeat)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HB_TIMEOUT    = DEF_HB_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               i_refclk,
    input  logic               i_rst_n,
    input  logic               i_pll_locked,
    input  logic               i_pll_hb,
    input  logic               i_clr_lost,
    output logic               o_pll_rst,
    output logic               o_sys_rst_n,
    output logic               o_ready,
    output logic               o_lock_lost,
    output logic [RETRY_W-1:0] o_retry_count
);

    localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HB_TC     = CNT_W'(HB_TIMEOUT - 1);

    pll_state_e       r_state;
    pll_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_locked_s;
    logic             w_hb_expired;
    logic             w_retry_inc;
    logic             w_lost_set;

    sync2 u_sync_locked (
        .i_clk   (i_refclk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_locked),
        .o_q     (w_locked_s)
    );

`ifdef PLL_HEARTBEAT_EN
    logic             w_hb_s;
    logic             r_hb_d;
    logic [CNT_W-1:0] r_hb_cnt;

    sync2 u_sync_hb (
        .i_clk   (i_refclk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_hb),
        .o_q     (w_hb_s)
    );

    // Held at zero outside RUN so every RUN entry starts a fresh window.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hb_d   <= 1'b0;
            r_hb_cnt <= '0;
        end else begin
            r_hb_d <= w_hb_s;
            if ((r_state != ST_RUN) || (w_hb_s ^ r_hb_d)) begin
                r_hb_cnt <= '0;
            end else begin
                r_hb_cnt <= r_hb_cnt + 1'b1;
            end
        end
    end

    assign w_hb_expired = (r_hb_cnt == HB_TC);
`else
    logic w_unused_hb;
    assign w_unused_hb  = ^{i_pll_hb, HB_TC};
    assign w_hb_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_lost_set  = 1'b0;
        case (r_state)
            ST_RST: begin
                if (r_cnt == RST_TC) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == LOCK_TC) begin
                    w_state_nxt = ST_RST;
                    w_retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                // A drop on the final stability cycle still wins.
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT;
                end else if (r_cnt == STABLE_TC) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_locked_s || w_hb_expired) begin
                    w_state_nxt = ST_RST;
                    w_retry_inc = 1'b1;
                    w_lost_set  = 1'b1;
                end
            end
            default: w_state_nxt = ST_RST;
        endcase
    end

    // Outputs are decoded from the next state so they move with the state register.
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RST;
            r_cnt         <= '0;
            o_pll_rst     <= 1'b1;
            o_sys_rst_n   <= 1'b0;
            o_ready       <= 1'b0;
            o_lock_lost   <= 1'b0;
            o_retry_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
            o_pll_rst   <= (w_state_nxt == ST_RST);
            o_sys_rst_n <= (w_state_nxt == ST_RUN);
            o_ready     <= (w_state_nxt == ST_RUN);
            if (w_lost_set) begin
                o_lock_lost <= 1'b1;
            end else if (i_clr_lost) begin
                o_lock_lost <= 1'b0;
            end
            if (w_retry_inc && (o_retry_count != '1)) begin
                o_retry_count <= o_retry_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer; heartbeat scenario follows PLL_HEARTBEAT_EN.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 200;
    localparam int STABLE_CYCLES = 32;
    localparam int HB_TIMEOUT    = 64;
    localparam int CNT_W         = 20;

    // Expected latencies in refclk edges, derived from the behavioural rules.
    localparam int SYNC_LAT    = 2;
    localparam int RELEASE_LAT = SYNC_LAT + STABLE_CYCLES + 1;
    localparam int LOSS_LAT    = SYNC_LAT + 1;
    localparam int GLITCH_LAT  = SYNC_LAT + 1 + 1 + LOCK_TIMEOUT;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_hb = 1'b0;
    logic       clr_lost = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;

    int   checks = 0;
    int   failures = 0;
    int   exp_retry = 0;
    logic exp_lost = 1'b0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .HB_TIMEOUT    (HB_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .i_refclk      (refclk),
        .i_rst_n       (rst_n),
        .i_pll_locked  (pll_locked),
        .i_pll_hb      (pll_hb),
        .i_clr_lost    (clr_lost),
        .o_pll_rst     (pll_rst),
        .o_sys_rst_n   (sys_rst_n),
        .o_ready       (ready),
        .o_lock_lost   (lock_lost),
        .o_retry_count (retry_count)
    );

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_rst_n;
            default: return ready;
        endcase
    endfunction

    // Counts falling refclk edges until the selected output reaches level (bounded).
    task automatic wait_level(input int sel, input logic level, input int limit, output int n);
        n = 0;
        while (sig(sel) !== level && n < limit) begin
            @(negedge refclk);
            n++;
        end
    endtask

    task automatic bump_retry();
        exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
    endtask

    task automatic apply_reset();
        @(negedge refclk);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        pll_hb = 1'b0;
        clr_lost = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        exp_retry = 0;
        exp_lost = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        checks++;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        checks++;
        if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++;
        if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
        checks++;
        if (retry_count !== 8'd0) begin failures++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
        rst_n = 1'b1;
        wait_level(0, 1'b0, RST_CYCLES + 10, n);
        checks++;
        if (n !== RST_CYCLES) begin failures++; $display("FAIL reset_rst_hold: got %0d cycles want %0d", n, RST_CYCLES); end
    endtask

    task automatic test_clean_lock();
        int n;
        int d;
        apply_reset();
        wait_level(0, 1'b0, RST_CYCLES + 10, n);
        checks++;
        if (n !== RST_CYCLES) begin failures++; $display("FAIL clean_rst_hold: got %0d want %0d", n, RST_CYCLES); end
        d = $urandom_range(1, LOCK_TIMEOUT - 50);
        repeat (d) @(negedge refclk);
        pll_locked = 1'b1;
        wait_level(1, 1'b1, RELEASE_LAT + 10, n);
        checks++;
        if (n !== RELEASE_LAT) begin failures++; $display("FAIL clean_release_lat: got %0d want %0d (d=%0d)", n, RELEASE_LAT, d); end
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL clean_ready: got %b want 1", ready); end
        checks++;
        if (pll_rst !== 1'b0) begin failures++; $display("FAIL clean_pll_rst: got %b want 0", pll_rst); end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL clean_retry: got %0d want %0d", retry_count, exp_retry); end
    endtask

    task automatic test_loss_in_run();
        int   n;
        int   hold;
        logic dropped;
        hold = $urandom_range(5, 100);
        dropped = 1'b0;
        repeat (hold) begin
            @(negedge refclk);
            if (ready !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0) begin failures++; $display("FAIL loss_run_hold: ready dropped=%b want 0", dropped); end
        pll_locked = 1'b0;
        wait_level(1, 1'b0, LOSS_LAT + 10, n);
        bump_retry();
        exp_lost = 1'b1;
        checks++;
        if (n !== LOSS_LAT) begin failures++; $display("FAIL loss_lat: got %0d want %0d", n, LOSS_LAT); end
        checks++;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst: got %b want 1", pll_rst); end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL loss_ready: got %b want 0", ready); end
        checks++;
        if (lock_lost !== exp_lost) begin failures++; $display("FAIL loss_lock_lost: got %b want %b", lock_lost, exp_lost); end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL loss_retry: got %0d want %0d", retry_count, exp_retry); end
        clr_lost = 1'b1;
        @(negedge refclk);
        clr_lost = 1'b0;
        exp_lost = 1'b0;
        checks++;
        if (lock_lost !== exp_lost) begin failures++; $display("FAIL loss_clr: got %b want %b", lock_lost, exp_lost); end
    endtask

    // Relock, then land a clr_lost pulse on the very edge that sets lock_lost.
    task automatic test_back_to_back();
        int n;
        pll_locked = 1'b1;
        wait_level(1, 1'b1, RST_CYCLES + RELEASE_LAT + 20, n);
        checks++;
        if (sys_rst_n !== 1'b1) begin failures++; $display("FAIL b2b_relock: sys_rst_n got %b want 1 after %0d cycles", sys_rst_n, n); end
        pll_locked = 1'b0;
        repeat (LOSS_LAT - 1) @(negedge refclk);
        clr_lost = 1'b1;
        @(negedge refclk);
        clr_lost = 1'b0;
        bump_retry();
        exp_lost = 1'b1;
        checks++;
        if (lock_lost !== exp_lost) begin failures++; $display("FAIL b2b_set_wins: got %b want %b", lock_lost, exp_lost); end
        checks++;
        if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL b2b_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL b2b_retry: got %0d want %0d", retry_count, exp_retry); end
    endtask

    task automatic test_async_reset();
        int n;
        pll_locked = 1'b1;
        wait_level(0, 1'b0, RST_CYCLES + 10, n);
        repeat (5) @(negedge refclk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_retry = 0;
        exp_lost = 1'b0;
        checks++;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
        checks++;
        if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL async_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++;
        if (lock_lost !== exp_lost) begin failures++; $display("FAIL async_lock_lost: got %b want %b", lock_lost, exp_lost); end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL async_retry: got %0d want %0d", retry_count, exp_retry); end
        @(negedge refclk);
        rst_n = 1'b1;
        wait_level(1, 1'b1, RST_CYCLES + RELEASE_LAT + 20, n);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL async_run_sys_rst_n: got %b want 0", sys_rst_n); end
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL async_run_ready: got %b want 0", ready); end
        checks++;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL async_run_pll_rst: got %b want 1", pll_rst); end
    endtask

    task automatic test_glitch();
        int   n;
        int   d;
        logic rose;
        logic moved;
        apply_reset();
        wait_level(0, 1'b0, RST_CYCLES + 10, n);
        d = $urandom_range(1, 100);
        repeat (d) @(negedge refclk);
        pll_locked = 1'b1;
        @(negedge refclk);
        pll_locked = 1'b0;
        n = 1;
        rose = 1'b0;
        moved = 1'b0;
        while (pll_rst !== 1'b1 && n < GLITCH_LAT + 50) begin
            if (sys_rst_n !== 1'b0 || ready !== 1'b0) rose = 1'b1;
            if (retry_count !== 8'(exp_retry)) moved = 1'b1;
            @(negedge refclk);
            n++;
        end
        checks++;
        if (rose !== 1'b0) begin failures++; $display("FAIL glitch_release: sys_rst_n/ready rose=%b want 0", rose); end
        checks++;
        if (moved !== 1'b0) begin failures++; $display("FAIL glitch_retry_moved: got %b want 0", moved); end
        checks++;
        if (n !== GLITCH_LAT) begin failures++; $display("FAIL glitch_wait_restart: got %0d want %0d", n, GLITCH_LAT); end
        bump_retry();
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL glitch_retry: got %0d want %0d", retry_count, exp_retry); end
    endtask

`ifdef PLL_HEARTBEAT_EN
    task automatic test_heartbeat();
        int   n;
        logic dropped;
        apply_reset();
        wait_level(0, 1'b0, RST_CYCLES + 10, n);
        pll_locked = 1'b1;
        wait_level(1, 1'b1, RELEASE_LAT + 10, n);
        wait_level(2, 1'b0, HB_TIMEOUT + 10, n);
        bump_retry();
        exp_lost = 1'b1;
        checks++;
        if (n !== HB_TIMEOUT) begin failures++; $display("FAIL hb_stall_lat: got %0d want %0d", n, HB_TIMEOUT); end
        checks++;
        if (pll_rst !== 1'b1) begin failures++; $display("FAIL hb_pll_rst: got %b want 1", pll_rst); end
        checks++;
        if (lock_lost !== exp_lost) begin failures++; $display("FAIL hb_lock_lost: got %b want %b", lock_lost, exp_lost); end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL hb_retry: got %0d want %0d", retry_count, exp_retry); end
        n = 0;
        while (sys_rst_n !== 1'b1 && n < RST_CYCLES + RELEASE_LAT + 20) begin
            if (n % 10 == 0) pll_hb = ~pll_hb;
            @(negedge refclk);
            n++;
        end
        dropped = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) pll_hb = ~pll_hb;
            @(negedge refclk);
            if (ready !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0) begin failures++; $display("FAIL hb_toggle_keeps_ready: dropped=%b want 0", dropped); end
        pll_hb = ~pll_hb;
        wait_level(2, 1'b0, HB_TIMEOUT + 20, n);
        bump_retry();
        checks++;
        if (n < HB_TIMEOUT || n > HB_TIMEOUT + SYNC_LAT + 2) begin
            failures++;
            $display("FAIL hb_stop_lat: got %0d want %0d..%0d", n, HB_TIMEOUT, HB_TIMEOUT + SYNC_LAT + 2);
        end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL hb_retry2: got %0d want %0d", retry_count, exp_retry); end
    endtask
`else
    task automatic test_heartbeat();
        int   n;
        logic dropped;
        apply_reset();
        wait_level(0, 1'b0, RST_CYCLES + 10, n);
        pll_locked = 1'b1;
        wait_level(1, 1'b1, RELEASE_LAT + 10, n);
        dropped = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge refclk);
            if (ready !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0) begin failures++; $display("FAIL hb_ignored: dropped=%b want 0", dropped); end
        checks++;
        if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL hb_ignored_retry: got %0d want %0d", retry_count, exp_retry); end
    endtask
`endif

    task automatic test_lock_timeout();
        int n;
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            wait_level(0, 1'b0, RST_CYCLES + 10, n);
            checks++;
            if (n !== RST_CYCLES) begin failures++; $display("FAIL timeout_rst_hold[%0d]: got %0d want %0d", i, n, RST_CYCLES); end
            wait_level(0, 1'b1, LOCK_TIMEOUT + 10, n);
            bump_retry();
            checks++;
            if (n !== LOCK_TIMEOUT) begin failures++; $display("FAIL timeout_lat[%0d]: got %0d want %0d", i, n, LOCK_TIMEOUT); end
            checks++;
            if (retry_count !== 8'(exp_retry)) begin failures++; $display("FAIL timeout_retry[%0d]: got %0d want %0d", i, retry_count, exp_retry); end
        end
        checks++;
        if (retry_count !== 8'd255) begin failures++; $display("FAIL timeout_saturate: got %0d want 255", retry_count); end
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_in_run();
        test_back_to_back();
        test_async_reset();
        test_glitch();
        test_heartbeat();
        test_lock_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
